// File: rtl/m6800_pkg.sv
// Shared constants and types for the E-synchronous peripheral cycle arbiter.
// Optional build macro used by the arbiter files: E_EXTERNAL_SYNC_EN.
package m6800_pkg;

    localparam int ECNT_W           = 4;
    localparam int E_PERIOD_DEF     = 10;
    localparam int E_HIGH_START_DEF = 6;
    localparam int VMA_SLOT_DEF     = 3;
    localparam int ACK_SLOT_DEF     = 9;

    typedef enum logic {
        IDLE,
        ACTIVE
    } arb_state_t;

endpackage

// File: rtl/e_phase_gen.sv
// E phase counter and E clock; with E_EXTERNAL_SYNC_EN the counter is
// aligned to a synchronized external E instead of generating E.
module e_phase_gen
    import m6800_pkg::*;
#(
    parameter int E_PERIOD     = E_PERIOD_DEF,
    parameter int E_HIGH_START = E_HIGH_START_DEF
) (
    input  logic              clk,
    input  logic              rst,
`ifdef E_EXTERNAL_SYNC_EN
    input  logic              e_in,
`else
    output logic              e,
`endif
    output logic [ECNT_W-1:0] ecnt,
    output logic              synced
);

    logic [ECNT_W-1:0] cnt;
    logic [ECNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt == ECNT_W'(E_PERIOD - 1)) ? '0 : cnt + 1'b1;
    assign ecnt    = cnt;

`ifdef E_EXTERNAL_SYNC_EN
    logic s0;
    logic s1;
    logic s2;
    logic fall;
    logic seen;

    assign fall   = s2 & ~s1;
    assign synced = seen;

    // Two synchronizer flops plus one stage of history for edge detect;
    // loading 2 makes count 0 coincide with the true E fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            seen <= 1'b0;
            cnt  <= '0;
        end else begin
            s0  <= e_in;
            s1  <= s0;
            s2  <= s1;
            if (fall) begin
                seen <= 1'b1;
                cnt  <= ECNT_W'(2);
            end else begin
                cnt  <= cnt_inc;
            end
        end
    end
`else
    assign synced = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            e   <= 1'b0;
        end else begin
            cnt <= cnt_inc;
            e   <= (cnt_inc >= ECNT_W'(E_HIGH_START));
        end
    end
`endif

endmodule

// File: rtl/e_cycle_arbiter.sv
// Shares the E-bus slot between a 68000 VPA cycle and a bridge master.
// Build macro E_EXTERNAL_SYNC_EN replaces the E output with an E_IN input.
module e_cycle_arbiter
    import m6800_pkg::*;
#(
    parameter int E_PERIOD     = E_PERIOD_DEF,
    parameter int E_HIGH_START = E_HIGH_START_DEF,
    parameter int VMA_SLOT     = VMA_SLOT_DEF,
    parameter int ACK_SLOT     = ACK_SLOT_DEF
) (
    input  logic              C7M,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
`ifdef E_EXTERNAL_SYNC_EN
    input  logic              E_IN,
`else
    output logic              E,
`endif
    output logic [ECNT_W-1:0] ECNT,
    output logic              VMA_n,
    output logic              GNT_ID,
    output logic              ACK0,
    output logic              ACK1,
    output logic              BUSY
);

    logic [ECNT_W-1:0] ecnt;
    logic              synced;

    e_phase_gen #(
        .E_PERIOD     (E_PERIOD),
        .E_HIGH_START (E_HIGH_START)
    ) u_phase (
        .clk    (C7M),
        .rst    (RESET),
`ifdef E_EXTERNAL_SYNC_EN
        .e_in   (E_IN),
`else
        .e      (E),
`endif
        .ecnt   (ecnt),
        .synced (synced)
    );

    assign ECNT = ecnt;

    arb_state_t state;
    arb_state_t state_n;
    logic [1:0] req;
    logic [1:0] armed;
    logic [1:0] armed_n;
    logic [1:0] eligible;
    logic [1:0] ack;
    logic [1:0] ack_n;
    logic       last;
    logic       last_n;
    logic       gnt;
    logic       gnt_n;
    logic       vma_n;
    logic       vma_nn;
    logic       busy;
    logic       busy_n;
    logic       winner;
    logic       at_vma;
    logic       at_ack;
    logic       at_wrap;

    assign req      = {REQ1, REQ0};
    assign eligible = req & armed & {2{synced}};
    assign at_vma   = (ecnt == ECNT_W'(VMA_SLOT));
    assign at_ack   = (ecnt == ECNT_W'(ACK_SLOT));
    assign at_wrap  = (ecnt == ECNT_W'(E_PERIOD - 1));
    assign winner   = (eligible == 2'b11) ? ~last : eligible[1];

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        last_n  = last;
        vma_nn  = vma_n;
        busy_n  = busy;
        ack_n   = 2'b00;
        unique case (state)
            IDLE: begin
                if (at_vma && (|eligible)) begin
                    state_n = ACTIVE;
                    gnt_n   = winner;
                    last_n  = winner;
                    vma_nn  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            ACTIVE: begin
                if (at_ack) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    // An aborted requester still lets the bus cycle run out,
                    // but gets no acknowledge.
                    if (gnt) ack_n[1] = req[1];
                    else     ack_n[0] = req[0];
                end
            end
        endcase
        if (at_wrap) vma_nn = 1'b1;
        armed_n = ~req | (armed & ~ack_n);
    end

    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            vma_n <= 1'b1;
            busy  <= 1'b0;
            ack   <= 2'b00;
            armed <= 2'b11;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            last  <= last_n;
            vma_n <= vma_nn;
            busy  <= busy_n;
            ack   <= ack_n;
            armed <= armed_n;
        end
    end

    assign VMA_n  = vma_n;
    assign GNT_ID = gnt;
    assign ACK0   = ack[0];
    assign ACK1   = ack[1];
    assign BUSY   = busy;

endmodule

// File: tb/tb_e_cycle_arbiter.sv
// Directed bench for e_cycle_arbiter (default build, internal E generation).
module tb_e_cycle_arbiter;

    logic       C7M   = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ0  = 1'b0;
    logic       REQ1  = 1'b0;
    logic       E;
    logic [3:0] ECNT;
    logic       VMA_n;
    logic       GNT_ID;
    logic       ACK0;
    logic       ACK1;
    logic       BUSY;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    int nsteps   = 0;
    int lat0;

    e_cycle_arbiter dut (
        .C7M    (C7M),
        .RESET  (RESET),
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .E      (E),
        .ECNT   (ECNT),
        .VMA_n  (VMA_n),
        .GNT_ID (GNT_ID),
        .ACK0   (ACK0),
        .ACK1   (ACK1),
        .BUSY   (BUSY)
    );

    always #5 C7M = ~C7M;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (ecnt model %0d)",
                     tag, got, exp, exp_cnt);
        end
    endtask

    task automatic step();
        @(posedge C7M);
        #2;
        nsteps++;
        if (!RESET) exp_cnt = (exp_cnt + 1) % 10;
        chk("ecnt", ECNT, exp_cnt);
        chk("e", E, exp_cnt >= 6);
    endtask

    task automatic goto(input int n);
        while (exp_cnt != n) step();
    endtask

    // Runs up to and including the next ecnt==0, checking VMA/BUSY/ACKs.
    task automatic period(input bit active, input bit a0, input bit a1,
                          input int drop_at);
        logic on;
        do begin
            step();
            on = active && (exp_cnt >= 4);
            chk("vma_n", VMA_n, !on);
            chk("busy", BUSY, on);
            chk("ack0", ACK0, (exp_cnt == 0) ? a0 : 1'b0);
            chk("ack1", ACK1, (exp_cnt == 0) ? a1 : 1'b0);
            if (exp_cnt == drop_at) REQ0 = 1'b0;
        end while (exp_cnt != 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) step();
        chk("rst_vma_n", VMA_n, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_gnt", GNT_ID, 0);
        chk("rst_ack0", ACK0, 0);
        chk("rst_ack1", ACK1, 0);
        RESET = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("free_vma_n", VMA_n, 1);
            chk("free_busy", BUSY, 0);
        end

        // Simultaneous requests: round robin, then no repeat while held.
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        period(1, 1, 0, -1);
        chk("tie_gnt0", GNT_ID, 0);
        period(1, 0, 1, -1);
        chk("tie_gnt1", GNT_ID, 1);
        period(0, 0, 0, -1);
        chk("tie_hold_gnt", GNT_ID, 1);
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        step();

        // Single requester 0 at ecnt 1.
        goto(1);
        REQ0 = 1'b1;
        period(1, 1, 0, -1);
        chk("r0_gnt", GNT_ID, 0);
        REQ0 = 1'b0;
        step();
        chk("r0_ack_pulse", ACK0, 0);

        // Late request 1 at ecnt 4 waits for the next slot.
        goto(4);
        REQ1 = 1'b1;
        lat0 = nsteps;
        period(0, 0, 0, -1);
        period(1, 0, 1, -1);
        chk("r1_latency", nsteps - lat0, 16);
        chk("r1_gnt", GNT_ID, 1);
        REQ1 = 1'b0;
        step();

        // Abort: drop at ecnt 6, cycle completes without ACK.
        REQ0 = 1'b1;
        period(1, 0, 0, 6);
        REQ0 = 1'b1;
        period(1, 1, 0, -1);
        chk("abort_regnt", GNT_ID, 0);
        REQ0 = 1'b0;

        // Reset in the middle of an active cycle.
        goto(1);
        REQ0 = 1'b1;
        goto(7);
        chk("pre_rst_vma_n", VMA_n, 0);
        chk("pre_rst_busy", BUSY, 1);
        RESET = 1'b1;
        exp_cnt = 0;
        #1;
        chk("mid_rst_vma_n", VMA_n, 1);
        chk("mid_rst_e", E, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_ecnt", ECNT, 0);
        REQ0 = 1'b0;
        step();
        chk("mid_rst_ack0", ACK0, 0);
        RESET = 1'b0;
        period(0, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
